// File: rtl/ax_sat_accum_pkg.sv
// Shared definitions for the a*x multiplier stage and the saturating accumulator:
// data width, saturation rails and the accumulator state encoding.
package ax_sat_accum_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] POS_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] NEG_MAX = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ax_sat_accum_sat_add32.sv
// Combinational two's-complement add that clamps to POS_MAX/NEG_MAX on overflow;
// ovf flags that the clamp was applied.
module sat_add32
  import ax_sat_accum_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              ovf
);

  logic [DATA_W:0] sum;

  // One guard bit: the top two bits disagree exactly when the result left the 32-bit range.
  always_comb begin
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    ovf = sum[DATA_W] != sum[DATA_W-1];
    if (ovf) begin
      y = sum[DATA_W] ? NEG_MAX : POS_MAX;
    end else begin
      y = sum[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/ax_sat_accum.sv
// Accumulates N_TERMS saturated products per group and hands out one saturated sum.
// Optional sticky clamp flag on out_sat when AX_ACC_SATFLAG_EN is defined.
module ax_sat_accum
  import ax_sat_accum_pkg::*;
#(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef AX_ACC_SATFLAG_EN
  ,
  output logic              out_sat
`endif
);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] sum_c;
  logic              ovf_c;
  logic              accept_c;

  sat_add32 u_sat_add (
    .a   (acc),
    .b   (in_data),
    .y   (sum_c),
    .ovf (ovf_c)
  );

`ifdef AX_ACC_SATFLAG_EN
  logic sat_nxt;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_c;
`endif

  // in_ready is registered from state, so accepts never depend on out_ready.
  assign accept_c = in_valid && in_ready;
  assign out_data = acc;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
`ifdef AX_ACC_SATFLAG_EN
    sat_nxt   = out_sat;
`endif
    case (state)
      IDLE, ACC: begin
        if (accept_c) begin
          acc_nxt   = sum_c;
          cnt_nxt   = cnt + CNT_W'(1);
`ifdef AX_ACC_SATFLAG_EN
          sat_nxt   = out_sat | ovf_c;
`endif
          state_nxt = (cnt_nxt == CNT_W'(N_TERMS)) ? DONE : ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
`ifdef AX_ACC_SATFLAG_EN
          sat_nxt   = 1'b0;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        acc_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
`ifdef AX_ACC_SATFLAG_EN
      out_sat   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      in_ready  <= (state_nxt != DONE);
      out_valid <= (state_nxt == DONE);
`ifdef AX_ACC_SATFLAG_EN
      out_sat   <= sat_nxt;
`endif
    end
  end

endmodule
